// File: rtl/fir_block_wb_if.sv
// Wishbone bus bundle for the block FIR engine; slave side faces the engine,
// master side faces the bus initiator.
interface fir_block_wb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0] wb_adr_i;
  logic          wb_cyc_i;
  logic          wb_stb_i;
  logic          wb_we_i;
  logic [3:0]    wb_sel_i;
  logic [DW-1:0] wb_dat_i;
  logic [DW-1:0] wb_dat_o;
  logic          wb_ack_o;
  logic          wb_err_o;

  modport slave (
    input  wb_adr_i, wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_dat_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );

  modport master (
    output wb_adr_i, wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );
endinterface

// File: rtl/fir_block_wb.sv
// Wishbone-mapped block FIR engine: programmable taps, shift with saturation,
// inter-block history, one time-shared multiply-accumulate.
module fir_block_wb #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int SW    = 16,
  parameter int CW    = 16,
  parameter int NTAPS = 8,
  parameter int BLK   = 32
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  fir_block_wb_if.slave wb,
  output logic          int_o
);
  localparam int ACCW = SW + CW + $clog2(NTAPS);
  localparam int XIW  = $clog2(BLK);
  localparam int KIW  = $clog2(NTAPS);
  localparam int NH   = NTAPS - 1;
  localparam int HIW  = (NH > 1) ? $clog2(NH) : 1;
  localparam logic [8:0] BLK_W   = 9'(BLK);
  localparam logic [8:0] NTAPS_W = 9'(NTAPS);
  localparam logic [6:0] KLAST   = 7'(NTAPS - 1);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_WB, S_DONE} state_t;

  state_t                 state_r;
  logic [8:0]             n_r;
  logic [6:0]             k_r;
  logic signed [ACCW-1:0] acc_r;
  logic signed [CW-1:0]   coef_r [NTAPS];
  logic signed [SW-1:0]   x_r    [BLK];
  logic signed [SW-1:0]   y_r    [BLK];
  logic signed [SW-1:0]   hist_r [NH];
  logic                   clr_hist_r, ie_r, done_r, wr_drop_r;
  logic [8:0]             len_r;
  logic [5:0]             shift_r;
  logic                   ack_r, err_r;
  logic [DW-1:0]          dat_r;

  logic                   busy_s, accept_s, wr_s, valid_s, wr_ok_s;
  logic [1:0]             region_s;
  logic [7:0]             idx_s;
  logic [DW-1:0]          rd_s;
  logic                   ctrl_wr_s, stat_wr_s, len_wr_s, shift_wr_s, coef_wr_s, x_wr_s;
  logic                   start_s, drop_s;
  logic [8:0]             eff_len_s, last_n_s;
  logic [9:0]             d_s;
  logic signed [SW-1:0]   samp_s;
  logic signed [CW-1:0]   coef_k_s;
  logic signed [SW+CW-1:0] prod_s;
  logic signed [ACCW-1:0] acc_base_s, acc_nxt_s, shifted_s;
  logic signed [SW-1:0]   ysat_s;
  logic signed [SW-1:0]   hist_nxt_s [NH];
  logic                   unused_s;

  function automatic logic signed [SW-1:0] sat_fn(input logic signed [ACCW-1:0] v);
    logic [ACCW-SW:0] top;
    top = v[ACCW-1:SW-1];
    if ((&top) || !(|top)) begin
      sat_fn = v[SW-1:0];
    end else if (v[ACCW-1]) begin
      sat_fn = {1'b1, {(SW-1){1'b0}}};
    end else begin
      sat_fn = {1'b0, {(SW-1){1'b1}}};
    end
  endfunction

  assign busy_s    = (state_r != S_IDLE);
  assign accept_s  = wb.wb_cyc_i & wb.wb_stb_i & ~ack_r & ~err_r;
  assign wr_s      = accept_s & wb.wb_we_i & (wb.wb_sel_i == 4'hF);
  assign region_s  = wb.wb_adr_i[11:10];
  assign idx_s     = wb.wb_adr_i[9:2];
  assign eff_len_s = ((len_r == 9'd0) || (len_r > BLK_W)) ? BLK_W : len_r;
  assign last_n_s  = eff_len_s - 9'd1;
  assign unused_s  = ^{wb.wb_adr_i[AW-1:12], wb.wb_adr_i[1:0], wb.wb_dat_i[DW-1:16]};

  // Address decode and read-data mux for the accepted access
  always_comb begin
    valid_s = 1'b0;
    rd_s    = {DW{1'b0}};
    case (region_s)
      2'd0: begin
        valid_s = (idx_s < 8'd4);
        case (idx_s[1:0])
          2'd0:    rd_s = DW'({ie_r, clr_hist_r, 1'b0});
          2'd1:    rd_s = DW'({wr_drop_r, done_r, busy_s});
          2'd2:    rd_s = DW'(len_r);
          2'd3:    rd_s = DW'(shift_r);
          default: rd_s = {DW{1'b0}};
        endcase
      end
      2'd1: begin
        valid_s = ({1'b0, idx_s} < NTAPS_W);
        rd_s    = DW'(coef_r[KIW'(idx_s)]);
      end
      2'd2: begin
        valid_s = ({1'b0, idx_s} < BLK_W);
        rd_s    = DW'(x_r[XIW'(idx_s)]);
      end
      2'd3: begin
        valid_s = ({1'b0, idx_s} < BLK_W);
        rd_s    = DW'(y_r[XIW'(idx_s)]);
      end
      default: begin
        valid_s = 1'b0;
        rd_s    = {DW{1'b0}};
      end
    endcase
  end

  assign wr_ok_s    = wr_s & valid_s;
  assign ctrl_wr_s  = wr_ok_s & (region_s == 2'd0) & (idx_s == 8'd0);
  assign stat_wr_s  = wr_ok_s & (region_s == 2'd0) & (idx_s == 8'd1);
  assign len_wr_s   = wr_ok_s & (region_s == 2'd0) & (idx_s == 8'd2);
  assign shift_wr_s = wr_ok_s & (region_s == 2'd0) & (idx_s == 8'd3);
  assign coef_wr_s  = wr_ok_s & (region_s == 2'd1);
  assign x_wr_s     = wr_ok_s & (region_s == 2'd2);
  assign start_s    = ctrl_wr_s & wb.wb_dat_i[0] & ~busy_s;
  assign drop_s     = busy_s & (len_wr_s | shift_wr_s | coef_wr_s | x_wr_s);

  // MAC operand select: negative sample indices reach back into history (~d == -d-1)
  always_comb begin
    d_s        = {1'b0, n_r} - {3'b000, k_r};
    samp_s     = d_s[9] ? hist_r[HIW'(~d_s)] : x_r[XIW'(d_s)];
    coef_k_s   = coef_r[KIW'(k_r)];
    prod_s     = coef_k_s * samp_s;
    acc_base_s = (k_r == 7'd0) ? {ACCW{1'b0}} : acc_r;
    acc_nxt_s  = acc_base_s + ACCW'(prod_s);
    shifted_s  = acc_r >>> shift_r;
    ysat_s     = sat_fn(shifted_s);
  end

  // Next history: the last NH samples of the extended input x', newest first
  always_comb begin
    logic [9:0] e_s;
    e_s = 10'd0;
    for (int j = 0; j < NH; j++) begin
      e_s = {1'b0, eff_len_s} - 10'd1 - 10'(j);
      hist_nxt_s[j] = e_s[9] ? hist_r[HIW'(~e_s)] : x_r[XIW'(e_s)];
    end
  end

  // Bus response, register file and run sequencer
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_r    <= S_IDLE;
      n_r        <= 9'd0;
      k_r        <= 7'd0;
      acc_r      <= {ACCW{1'b0}};
      clr_hist_r <= 1'b0;
      ie_r       <= 1'b0;
      done_r     <= 1'b0;
      wr_drop_r  <= 1'b0;
      len_r      <= 9'd0;
      shift_r    <= 6'd0;
      ack_r      <= 1'b0;
      err_r      <= 1'b0;
      dat_r      <= {DW{1'b0}};
      for (int i = 0; i < NTAPS; i++) coef_r[i] <= {CW{1'b0}};
      for (int i = 0; i < BLK; i++) begin
        x_r[i] <= {SW{1'b0}};
        y_r[i] <= {SW{1'b0}};
      end
      for (int i = 0; i < NH; i++) hist_r[i] <= {SW{1'b0}};
    end else begin
      ack_r <= accept_s & valid_s;
      err_r <= accept_s & ~valid_s;
      dat_r <= (accept_s & valid_s) ? rd_s : {DW{1'b0}};

      if (ctrl_wr_s) begin
        ie_r       <= wb.wb_dat_i[2];
        clr_hist_r <= wb.wb_dat_i[1];
      end
      if (len_wr_s & ~busy_s)   len_r   <= wb.wb_dat_i[8:0];
      if (shift_wr_s & ~busy_s) shift_r <= wb.wb_dat_i[5:0];
      if (coef_wr_s & ~busy_s)  coef_r[KIW'(idx_s)] <= wb.wb_dat_i[CW-1:0];
      if (x_wr_s & ~busy_s)     x_r[XIW'(idx_s)]    <= wb.wb_dat_i[SW-1:0];

      // A completion in the same cycle as a W1C keeps done set
      done_r    <= (done_r & ~(stat_wr_s & wb.wb_dat_i[1])) | (state_r == S_DONE);
      wr_drop_r <= (wr_drop_r & ~(stat_wr_s & wb.wb_dat_i[2])) | drop_s;

      case (state_r)
        S_IDLE: begin
          if (start_s) begin
            state_r <= S_MAC;
            n_r     <= 9'd0;
            k_r     <= 7'd0;
            if (wb.wb_dat_i[1]) begin
              for (int i = 0; i < NH; i++) hist_r[i] <= {SW{1'b0}};
            end
          end
        end
        S_MAC: begin
          acc_r <= acc_nxt_s;
          if (k_r == KLAST) begin
            state_r <= S_WB;
          end else begin
            k_r <= k_r + 7'd1;
          end
        end
        S_WB: begin
          y_r[XIW'(n_r)] <= ysat_s;
          k_r            <= 7'd0;
          if (n_r == last_n_s) begin
            state_r <= S_DONE;
          end else begin
            n_r     <= n_r + 9'd1;
            state_r <= S_MAC;
          end
        end
        S_DONE: begin
          for (int i = 0; i < NH; i++) hist_r[i] <= hist_nxt_s[i];
          state_r <= S_IDLE;
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

  assign wb.wb_dat_o = dat_r;
  assign wb.wb_ack_o = ack_r;
  assign wb.wb_err_o = err_r;
  assign int_o       = done_r & ie_r;
endmodule

// File: tb/tb_fir_block_wb.sv
// Directed bench for fir_block_wb: hand-computed FIR results, run timing,
// bus protocol and reset behaviour.
module tb_fir_block_wb;
  localparam logic [31:0] A_CTRL   = 32'h000;
  localparam logic [31:0] A_STATUS = 32'h004;
  localparam logic [31:0] A_LEN    = 32'h008;
  localparam logic [31:0] A_SHIFT  = 32'h00C;
  localparam logic [31:0] A_COEF   = 32'h400;
  localparam logic [31:0] A_X      = 32'h800;
  localparam logic [31:0] A_Y      = 32'hC00;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic int_o;
  int   errors = 0;
  int   checks = 0;
  int   cyc_cnt = 0;
  logic last_ack, last_err;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  fir_block_wb_if #(.AW(32), .DW(32)) wb ();

  fir_block_wb #(.AW(32), .DW(32), .SW(16), .CW(16), .NTAPS(8), .BLK(32)) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .wb       (wb),
    .int_o    (int_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      output logic [31:0] rdat);
    int n;
    @(negedge clk);
    wb.wb_cyc_i = 1'b1;
    wb.wb_stb_i = 1'b1;
    wb.wb_we_i  = we;
    wb.wb_adr_i = adr;
    wb.wb_dat_i = dat;
    wb.wb_sel_i = 4'hF;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(wb.wb_ack_o || wb.wb_err_o) && n < 8);
    last_ack = wb.wb_ack_o;
    last_err = wb.wb_err_o;
    rdat     = wb.wb_dat_o;
    wb.wb_cyc_i = 1'b0;
    wb.wb_stb_i = 1'b0;
    wb.wb_we_i  = 1'b0;
    if (!(last_ack || last_err)) check("bus_timeout", 32'(last_ack | last_err), 32'd1);
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
    logic [31:0] dummy;
    xfer(1'b1, adr, dat, dummy);
  endtask

  task automatic rd(input logic [31:0] adr, output logic [31:0] dat);
    xfer(1'b0, adr, 32'h0, dat);
  endtask

  task automatic wait_idle();
    logic [31:0] s;
    int n;
    s = 32'h1;
    n = 0;
    while (s[0] && n < 600) begin
      rd(A_STATUS, s);
      n++;
    end
    check("run_idle", 32'(s[0]), 32'h0);
  endtask

  // Start a run with ie set and count cycles from the start edge to int_o
  task automatic run_timed(input logic [31:0] ctrl, output int cycles);
    int t0, n;
    wr(A_CTRL, ctrl);
    t0 = cyc_cnt;
    n = 0;
    while (!int_o && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    cycles = cyc_cnt - t0;
  endtask

  task automatic check_y(input string tag, input int cnt, input logic [31:0] exp_arr [16]);
    logic [31:0] d;
    for (int i = 0; i < cnt; i++) begin
      rd(A_Y + 32'(4 * i), d);
      check($sformatf("%s_y%0d", tag, i), d, exp_arr[i]);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [31:0] e [16];
    int cyc;
    logic [3:0] ack_seen;

    wb.wb_cyc_i = 1'b0;
    wb.wb_stb_i = 1'b0;
    wb.wb_we_i  = 1'b0;
    wb.wb_adr_i = 32'h0;
    wb.wb_dat_i = 32'h0;
    wb.wb_sel_i = 4'h0;

    #23;
    check("rst_ack", 32'(wb.wb_ack_o), 32'h0);
    check("rst_err", 32'(wb.wb_err_o), 32'h0);
    check("rst_dat", wb.wb_dat_o, 32'h0);
    check("rst_int", 32'(int_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rd(A_CTRL, d);   check("rst_ctrl", d, 32'h0);
    rd(A_STATUS, d); check("rst_status", d, 32'h0);

    // Impulse response through coefficients 1..8
    for (int k = 0; k < 8; k++) wr(A_COEF + 32'(4 * k), 32'(k + 1));
    wr(A_X, 32'd1);
    for (int i = 1; i < 16; i++) wr(A_X + 32'(4 * i), 32'd0);
    wr(A_LEN, 32'd16);
    wr(A_SHIFT, 32'd0);
    wr(A_CTRL, 32'h3);
    wait_idle();
    rd(A_STATUS, d); check("imp_status", d, 32'h2);
    check("imp_int_ie0", 32'(int_o), 32'h0);
    for (int i = 0; i < 16; i++) e[i] = (i < 8) ? 32'(i + 1) : 32'h0;
    check_y("imp", 16, e);
    wr(A_STATUS, 32'h2);
    rd(A_STATUS, d); check("imp_w1c", d, 32'h0);
    run_timed(32'h7, cyc);
    check("imp_busy_cycles", 32'(cyc), 32'd145);
    check("imp_int_ie1", 32'(int_o), 32'h1);
    wr(A_STATUS, 32'h2);
    check("imp_int_clr", 32'(int_o), 32'h0);

    // Saturation at both rails, then shift
    for (int k = 0; k < 8; k++) wr(A_COEF + 32'(4 * k), 32'h7FFF);
    for (int i = 0; i < 4; i++) wr(A_X + 32'(4 * i), 32'h7FFF);
    wr(A_LEN, 32'd4);
    wr(A_CTRL, 32'h3);
    wait_idle();
    for (int i = 0; i < 4; i++) e[i] = 32'h0000_7FFF;
    check_y("satp", 4, e);
    for (int i = 0; i < 4; i++) wr(A_X + 32'(4 * i), 32'h8000);
    wr(A_CTRL, 32'h3);
    wait_idle();
    for (int i = 0; i < 4; i++) e[i] = 32'hFFFF_8000;
    check_y("satn", 4, e);
    for (int k = 0; k < 8; k++) wr(A_COEF + 32'(4 * k), 32'd1);
    for (int i = 0; i < 4; i++) wr(A_X + 32'(4 * i), 32'd4);
    wr(A_SHIFT, 32'd1);
    wr(A_CTRL, 32'h3);
    wait_idle();
    for (int i = 0; i < 4; i++) e[i] = 32'(2 * (i + 1));
    check_y("shift", 4, e);
    wr(A_SHIFT, 32'd0);

    // History carried between blocks
    for (int i = 0; i < 4; i++) wr(A_X + 32'(4 * i), 32'd1);
    wr(A_CTRL, 32'h3);
    wait_idle();
    for (int i = 0; i < 4; i++) e[i] = 32'(i + 1);
    check_y("blk1", 4, e);
    wr(A_CTRL, 32'h1);
    wait_idle();
    for (int i = 0; i < 4; i++) e[i] = 32'(i + 5);
    check_y("blk2", 4, e);
    wr(A_CTRL, 32'h3);
    wait_idle();
    for (int i = 0; i < 4; i++) e[i] = 32'(i + 1);
    check_y("blk2clr", 4, e);

    // Writes while busy are dropped; start while busy is ignored
    wr(A_STATUS, 32'h6);
    wr(A_LEN, 32'd16);
    wr(A_CTRL, 32'h7);
    cyc = cyc_cnt;
    wr(A_COEF, 32'h55);
    wr(A_CTRL, 32'h5);
    while (!int_o && (cyc_cnt - cyc) < 1000) begin
      @(posedge clk);
      #1;
    end
    check("busy_start_len", 32'(cyc_cnt - cyc), 32'd145);
    rd(A_STATUS, d); check("busy_wr_drop", d, 32'h6);
    rd(A_COEF, d);   check("busy_coef_kept", d, 32'd1);
    rd(A_COEF + 32'd32, d);
    check("coef8_err", 32'(last_err), 32'h1);
    check("coef8_ack", 32'(last_ack), 32'h0);
    @(negedge clk);
    @(negedge clk);
    wb.wb_cyc_i = 1'b1;
    wb.wb_stb_i = 1'b1;
    wb.wb_we_i  = 1'b0;
    wb.wb_adr_i = A_STATUS;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      ack_seen[i] = wb.wb_ack_o;
    end
    wb.wb_cyc_i = 1'b0;
    wb.wb_stb_i = 1'b0;
    check("ack_pulse", 32'(ack_seen), 32'h5);
    wr(A_STATUS, 32'h6);
    rd(A_STATUS, d); check("w1c_both", d, 32'h0);

    // LEN corner cases
    wr(A_LEN, 32'd0);
    run_timed(32'h7, cyc);
    check("len0_cycles", 32'(cyc), 32'd289);
    rd(A_Y + 32'd28, d); check("len0_y7", d, 32'd4);
    rd(A_Y + 32'd36, d); check("len0_y9", d, 32'd2);
    rd(A_Y + 32'd124, d); check("len0_y31", d, 32'd0);
    wr(A_STATUS, 32'h6);
    wr(A_X, 32'd5);
    wr(A_LEN, 32'd1);
    run_timed(32'h7, cyc);
    check("len1_cycles", 32'(cyc), 32'd10);
    rd(A_Y, d);         check("len1_y0", d, 32'd5);
    rd(A_Y + 32'd4, d); check("len1_y1_kept", d, 32'd2);

    // Asynchronous reset in the middle of a run
    wr(A_LEN, 32'd16);
    wr(A_CTRL, 32'h7);
    check("pre_rst_int", 32'(int_o), 32'h1);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_int", 32'(int_o), 32'h0);
    check("arst_ack", 32'(wb.wb_ack_o), 32'h0);
    check("arst_err", 32'(wb.wb_err_o), 32'h0);
    check("arst_dat", wb.wb_dat_o, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd(A_STATUS, d);    check("post_rst_status", d, 32'h0);
    rd(A_CTRL, d);      check("post_rst_ctrl", d, 32'h0);
    rd(A_Y, d);         check("post_rst_y0", d, 32'h0);
    rd(A_Y + 32'd4, d); check("post_rst_y1", d, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
